// File: rtl/leaf_link_pkg.sv
// Shared definitions for the BFT-side leaf link endpoint.
// Holds the 49-bit packet field layout, the packet and replay-entry types, the default ack port
// and the transmit FSM state encoding.
package leaf_link_pkg;

   localparam int unsigned PKT_W     = 49;
   localparam int unsigned VALID_BIT = 48;
   localparam int unsigned LEAF_MSB  = 47;
   localparam int unsigned LEAF_LSB  = 43;
   localparam int unsigned PORT_MSB  = 42;
   localparam int unsigned PORT_LSB  = 39;
   localparam int unsigned SEQ_MSB   = 38;
   localparam int unsigned SEQ_LSB   = 32;
   localparam int unsigned DATA_MSB  = 31;
   localparam int unsigned DATA_LSB  = 0;

   // Replay buffer entry: {seq, data}
   localparam int unsigned ENTRY_W = SEQ_MSB - DATA_LSB + 1;

   localparam logic [3:0] ACK_PORT_DEFAULT = 4'hF;

   typedef logic [PKT_W-1:0] packet_t;

   typedef enum logic {
      StSend,
      StReplay
   } tx_state_e;

   function automatic packet_t make_packet(logic [4:0] leaf, logic [3:0] port,
                                           logic [ENTRY_W-1:0] entry);
      return {1'b1, leaf, port, entry};
   endfunction

endpackage

// File: rtl/leaf_replay_ram.sv
// Replay buffer storage: DEPTH x WIDTH simple dual-port RAM.
// Ports: clk; we/waddr/wdata synchronous write; raddr/rdata asynchronous read.
// Contents are not reset; the owner's pointers define which entries are meaningful.
module leaf_replay_ram
   import leaf_link_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = ENTRY_W
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/leaf_bft_link_tx.sv
// BFT-side endpoint of a page leaf link.
// Packetizes the 32-bit source stream (s_data/s_valid/s_ready) into 49-bit packets on
// dout_leaf_bft2interface, keeps every sent packet until acked, and replays unacked packets
// when resend is raised (replay_active high meanwhile). The return link din_leaf_interface2bft
// is decoded: ack packets free buffer slots, all others appear as m_data/m_port/m_valid.
module leaf_bft_link_tx
   import leaf_link_pkg::*;
#(
   parameter int unsigned DEPTH     = 16,
   parameter logic [4:0]  DEST_LEAF = 5'd0,
   parameter logic [3:0]  DEST_PORT = 4'd1,
   parameter logic [3:0]  ACK_PORT  = ACK_PORT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [48:0] dout_leaf_bft2interface,
   input  logic [48:0] din_leaf_interface2bft,
   input  logic        resend,
   output logic [31:0] m_data,
   output logic [3:0]  m_port,
   output logic        m_valid,
   output logic        replay_active
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   // head: oldest unacked, send_ptr: next to transmit, tail: next free, hwm: replay end point
   logic [PW-1:0] head_q, head_d, send_ptr_q, send_ptr_d, tail_q, tail_d, hwm_q, hwm_d;
   logic [6:0]    wr_seq_q;
   tx_state_e     state_q, state_d;
   packet_t       dout_q, dout_d;
   packet_t       din;
   logic          m_valid_q;
   logic [31:0]   m_data_q;
   logic [3:0]    m_port_q;

   logic [ENTRY_W-1:0] rd_entry;
   logic               accept;
   logic [PW-1:0]      occupancy, in_flight, ack_step;
   logic               din_is_ack, din_is_rx;
   logic [7:0]         ack_req, ack_max;
   logic               unused_din;

   assign din        = din_leaf_interface2bft;
   assign unused_din = ^{din[LEAF_MSB:LEAF_LSB], din[SEQ_MSB:SEQ_LSB]};

   assign occupancy = tail_q - head_q;
   // Occupancy never exceeds DEPTH, so its MSB is set exactly when the buffer is full.
   assign s_ready   = ~occupancy[PW-1];
   assign accept    = s_valid & s_ready;
   assign tail_d    = accept ? tail_q + PW'(1) : tail_q;

   leaf_replay_ram #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_ram (
      .clk   (clk),
      .we    (accept),
      .waddr (tail_q[AW-1:0]),
      .wdata ({wr_seq_q, s_data}),
      .raddr (send_ptr_q[AW-1:0]),
      .rdata (rd_entry)
   );

   // Return link decode; acks are clipped so head never passes what has been sent.
   assign din_is_ack = din[VALID_BIT] && (din[PORT_MSB:PORT_LSB] == ACK_PORT);
   assign din_is_rx  = din[VALID_BIT] && !din_is_ack;
   assign in_flight  = send_ptr_q - head_q;
   assign ack_req    = {3'b000, din[4:0]};
   assign ack_max    = 8'(in_flight);
   assign ack_step   = !din_is_ack          ? '0        :
                       (ack_req > ack_max)  ? in_flight : ack_req[PW-1:0];
   assign head_d     = head_q + ack_step;

   always_comb begin
      state_d    = state_q;
      send_ptr_d = send_ptr_q;
      hwm_d      = hwm_q;
      dout_d     = '0;
      if (resend && (state_q == StReplay || send_ptr_q != head_d)) begin
         // Rewind to the post-ack head; nothing is emitted in the rewind cycle.
         send_ptr_d = head_d;
         if (state_q == StSend) begin
            hwm_d   = send_ptr_q;
            state_d = StReplay;
         end else if (head_d == hwm_q) begin
            state_d = StSend;
         end
      end else if (send_ptr_q != tail_q) begin
         dout_d     = make_packet(DEST_LEAF, DEST_PORT, rd_entry);
         send_ptr_d = send_ptr_q + PW'(1);
         if (state_q == StReplay && (send_ptr_q + PW'(1)) == hwm_q) begin
            state_d = StSend;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q     <= '0;
         send_ptr_q <= '0;
         tail_q     <= '0;
         hwm_q      <= '0;
         wr_seq_q   <= '0;
         state_q    <= StSend;
         dout_q     <= '0;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
         m_port_q   <= '0;
      end else begin
         head_q     <= head_d;
         send_ptr_q <= send_ptr_d;
         tail_q     <= tail_d;
         hwm_q      <= hwm_d;
         state_q    <= state_d;
         dout_q     <= dout_d;
         m_valid_q  <= din_is_rx;
         if (accept) begin
            wr_seq_q <= wr_seq_q + 7'd1;
         end
         if (din_is_rx) begin
            m_data_q <= din[DATA_MSB:DATA_LSB];
            m_port_q <= din[PORT_MSB:PORT_LSB];
         end
      end
   end

   assign dout_leaf_bft2interface = dout_q;
   assign m_valid                 = m_valid_q;
   assign m_data                  = m_data_q;
   assign m_port                  = m_port_q;
   assign replay_active           = (state_q == StReplay);

endmodule

// File: tb/tb_leaf_bft_link_tx.sv
// Scoreboard bench for leaf_bft_link_tx: stimulus pushes expected packets / receive words into
// queues, negedge monitors pop and compare whenever the DUT presents valid output.
module tb_leaf_bft_link_tx;
   import leaf_link_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [48:0] dout;
   logic [48:0] din;
   logic        resend;
   logic [31:0] m_data;
   logic [3:0]  m_port;
   logic        m_valid;
   logic        replay_active;

   always #5 clk = ~clk;

   leaf_bft_link_tx #(
      .DEPTH     (16),
      .DEST_LEAF (5'd0),
      .DEST_PORT (4'd1),
      .ACK_PORT  (4'hF)
   ) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .s_data                  (s_data),
      .s_valid                 (s_valid),
      .s_ready                 (s_ready),
      .dout_leaf_bft2interface (dout),
      .din_leaf_interface2bft  (din),
      .resend                  (resend),
      .m_data                  (m_data),
      .m_port                  (m_port),
      .m_valid                 (m_valid),
      .replay_active           (replay_active)
   );

   int          n_checks = 0;
   int          n_fail = 0;
   packet_t     sb_q[$];
   logic [35:0] m_q[$];
   logic [31:0] mdl_data [0:255];
   int          mdl_tail = 0;
   int          mdl_head = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic packet_t pkt(int idx);
      return {1'b1, 5'd0, 4'd1, 7'(idx), mdl_data[idx]};
   endfunction

   // Monitors
   always @(negedge clk) begin
      if (dout[48]) begin
         if (sb_q.size() == 0) begin
            check("dout_unexpected", 64'(dout), 64'd0);
         end else begin
            packet_t exp_p;
            exp_p = sb_q.pop_front();
            check("dout_pkt", 64'(dout), 64'(exp_p));
         end
      end
      if (m_valid) begin
         if (m_q.size() == 0) begin
            check("m_unexpected", 64'({m_port, m_data}), 64'd0);
         end else begin
            logic [35:0] exp_m;
            exp_m = m_q.pop_front();
            check("m_word", 64'({m_port, m_data}), 64'(exp_m));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      s_valid = 1'b0;
      resend  = 1'b0;
      din     = '0;
      sb_q.delete();
      m_q.delete();
      mdl_tail = 0;
      mdl_head = 0;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic send_word(input logic [31:0] d);
      int guard;
      s_data  = d;
      s_valid = 1'b1;
      guard   = 0;
      while (!s_ready && guard < 50) begin
         tick();
         guard++;
      end
      if (guard == 50) check("accept_timeout", 64'(s_ready), 64'd1);
      mdl_data[mdl_tail] = d;
      sb_q.push_back(pkt(mdl_tail));
      mdl_tail++;
      tick();
      s_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (sb_q.size() != 0 && guard < 60) begin
         tick();
         guard++;
      end
      check("drain", 64'(sb_q.size()), 64'd0);
   endtask

   // Model of the clipped ack; assumes every accepted word has already been sent.
   task automatic model_ack(input int n);
      int infl;
      infl = mdl_tail - mdl_head;
      mdl_head += (n > infl) ? infl : n;
   endtask

   function automatic logic [48:0] ack_pkt(input logic [4:0] n);
      return {1'b1, 5'd0, 4'hF, 7'd0, 27'd0, n};
   endfunction

   task automatic send_ack(input logic [4:0] n);
      din = ack_pkt(n);
      model_ack(int'(n));
      tick();
      din = '0;
   endtask

   task automatic push_replay();
      for (int i = mdl_head; i < mdl_tail; i++) sb_q.push_back(pkt(i));
   endtask

   initial begin
      s_data  = '0;
      s_valid = 1'b0;
      din     = '0;
      resend  = 1'b0;

      // Reset state
      repeat (2) tick();
      check("rst_dout", 64'(dout), 64'd0);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_data", 64'(m_data), 64'd0);
      check("rst_m_port", 64'(m_port), 64'd0);
      check("rst_replay", 64'(replay_active), 64'd0);
      reset_n = 1'b1;
      tick();
      check("rst_s_ready", 64'(s_ready), 64'd1);

      // Stream 0x100..0x103 with two-cycle latency, then fill to 16
      send_word(32'h100);
      check("lat_not_yet", 64'(dout), 64'd0);
      send_word(32'h101);
      check("lat_first_pkt", 64'(dout), 64'(pkt(0)));
      send_word(32'h102);
      send_word(32'h103);
      for (int i = 4; i < 16; i++) send_word(32'h100 + 32'(i));
      check("full_s_ready", 64'(s_ready), 64'd0);
      wait_drain();
      check("full_hold", 64'(s_ready), 64'd0);
      send_ack(5'd5);
      check("ack5_s_ready", 64'(s_ready), 64'd1);

      // Send 8, ack 3, resend: replay seq 3..7, a word accepted mid-replay goes out as seq 8
      do_reset();
      for (int i = 0; i < 8; i++) send_word(32'h200 + 32'(i));
      wait_drain();
      send_ack(5'd3);
      resend = 1'b1;
      push_replay();
      tick();
      resend = 1'b0;
      check("replay_on", 64'(replay_active), 64'd1);
      send_word(32'h300);
      repeat (3) tick();
      check("replay_still", 64'(replay_active), 64'd1);
      tick();
      check("replay_done", 64'(replay_active), 64'd0);
      wait_drain();

      // Ack 2 together with resend after 6 sent: replay starts at seq 2
      do_reset();
      for (int i = 0; i < 6; i++) send_word(32'h500 + 32'(i));
      wait_drain();
      din    = ack_pkt(5'd2);
      resend = 1'b1;
      model_ack(2);
      push_replay();
      tick();
      din    = '0;
      resend = 1'b0;
      check("replay_on2", 64'(replay_active), 64'd1);
      wait_drain();

      // Receive path, then an over-sized ack clipped to the 4 unacked packets
      m_q.push_back({4'd2, 32'hDEADBEEF});
      din = {1'b1, 5'd0, 4'd2, 7'd0, 32'hDEADBEEF};
      tick();
      din = '0;
      check("m_strobe", 64'(m_valid), 64'd1);
      tick();
      check("m_strobe_len", 64'(m_valid), 64'd0);
      send_ack(5'd31);
      resend = 1'b1;
      tick();
      resend = 1'b0;
      check("no_replay", 64'(replay_active), 64'd0);
      repeat (3) tick();
      send_word(32'h600);
      wait_drain();

      // Reset during replay
      do_reset();
      for (int i = 0; i < 8; i++) send_word(32'h700 + 32'(i));
      wait_drain();
      resend = 1'b1;
      push_replay();
      tick();
      resend = 1'b0;
      repeat (2) tick();
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_async_dout", 64'(dout), 64'd0);
      check("rst_async_replay", 64'(replay_active), 64'd0);
      sb_q.delete();
      mdl_tail = 0;
      mdl_head = 0;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      check("rst2_s_ready", 64'(s_ready), 64'd1);
      send_word(32'hABC);
      wait_drain();

      check("m_q_empty", 64'(m_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/leaf_bft_link_tx.md
Name: leaf_bft_link_tx

Overview:
- BFT-side endpoint of a page leaf link: the counterpart to the page's leaf interface.
- Packetizes a 32-bit source stream into 49-bit packets that drive the page's bft-to-interface input.
- Holds every sent packet in a replay buffer until the page acknowledges it, and retransmits unacked packets when the page raises resend.
- Decodes the page's interface-to-bft output: ack packets free buffer slots; all other packets are forwarded to a receive stream.

Parameters:
- DEPTH, 16, replay buffer entries (power of 2, 4..64).
- DEST_LEAF, 5'd0, leaf address placed in header bits [47:43].
- DEST_PORT, 4'd1, destination port placed in header bits [42:39].
- ACK_PORT, 4'hF, port value identifying an ack packet on the return link.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- s_data  in  32  source payload.
- s_valid  in  1  source word valid.
- s_ready  out  1  buffer can accept a word.
- dout_leaf_bft2interface  out  49  packet to page: [48] valid, [47:43] leaf, [42:39] port, [38:32] seq, [31:0] data.
- din_leaf_interface2bft  in  49  packet from page, same field layout.
- resend  in  1  page request to replay all unacked packets.
- m_data  out  32  received payload (no backpressure).
- m_port  out  4  received port field.
- m_valid  out  1  one-cycle strobe per received non-ack packet.
- replay_active  out  1  high while in REPLAY state.

Behaviour:
- Reset (async assert, sync release): all pointers = 0, state = SEND.
  - dout_leaf_bft2interface = 0, m_valid = 0, m_data = 0, m_port = 0, replay_active = 0.
  - s_ready = 1 once reset is released.
- Pointers are log2(DEPTH)+1 bits (wrap bit): head (oldest unacked), send_ptr, tail.
  - occupancy = tail - head, modulo arithmetic.
  - s_ready = occupancy < DEPTH.
- Accept: when s_valid && s_ready, write s_data at buf[tail] and increment tail.
- Sequence number: seq = low 7 bits of the absolute write index, stored alongside the data. A replayed packet carries its original seq.
- Transmit: each cycle, if send_ptr != tail, register {1, DEST_LEAF, DEST_PORT, seq, data} from buf[send_ptr] and increment send_ptr; otherwise register 49'b0.
  - Latency: a word accepted in cycle N appears on dout in cycle N+2.
  - Sustained rate is 1 packet/cycle.
- Ack decode (return link, registered 1 cycle): din[48] && din[42:39] == ACK_PORT.
  - ackn = din[4:0], clipped to (send_ptr - head).
  - head += ackn. An ack of 0 is a no-op.
- Non-ack return packet: din[48] with any other port.
  - Next cycle: m_valid = 1, m_data = din[31:0], m_port = din[42:39].
- FSM SEND / REPLAY:
  - SEND to REPLAY on a resend pulse with send_ptr != head: send_ptr <= head.
  - REPLAY to SEND when send_ptr reaches its value at the time of the resend (the high-water mark). After that, new words stream normally.
  - Resend while already in REPLAY restarts from the current head.
  - Resend with nothing unacked leaves the state in SEND; no packets are emitted.
- Simultaneous events:
  - Ack and resend in the same cycle: apply the ack to head first, then send_ptr <= new head.
  - Accept and ack in the same cycle: both take effect; occupancy changes by the net amount.
  - Accept while full: impossible, because s_ready = 0.
- Replay ordering: new words continue to be accepted during REPLAY but are sent only after the replayed packets, in order.
- Reset mid-replay: all buffered data is discarded and the outputs are reset.

Decomposition:
- Package leaf_link_pkg holds:
  - field position constants (VALID_BIT = 48, LEAF_MSB/LSB, PORT_MSB/LSB, SEQ_MSB/LSB, DATA_MSB/LSB);
  - the packet typedef (49-bit);
  - the default ACK_PORT constant.
- One sub-module, leaf_replay_ram: simple dual-port RAM, DEPTH x 39 bits (seq + data), one synchronous write port and one asynchronous read port.

Test Plan:
- Stream 0x100..0x103 with no acks → dout carries seq 0..3 and data 0x100..0x103 on consecutive cycles, first packet 2 cycles after the first accept; occupancy 4.
- Fill 16 words with no ack → s_ready drops after the 16th accept; inject ack with data = 5 → s_ready = 1 the cycle after the ack is registered, head = 5.
- Send 8, ack 3, pulse resend → replay_active = 1, then packets seq 3..7 are re-emitted, then replay_active = 0 and new words continue at seq 8.
- Resend in the same cycle as ack of 2 (after 6 sent) → replay starts at seq 2, not seq 0.
- Return packet {1, leaf 0, port 2, data 0xDEADBEEF} → m_valid strobe for 1 cycle, m_data = 0xDEADBEEF, m_port = 2; ack with count 31 while only 4 are unacked → head advances by exactly 4.
- Assert reset_n = 0 mid-replay → dout = 0 immediately (async), replay_active = 0; after release, s_ready = 1 and the first new word is sent with seq 0.
